// File: rtl/blk_coding_scheduler.sv
// Block-coding sequencer: serial payload load, CRC/turbo handshakes, rate-matched
// bit counting, with a watchdog that aborts any stalled handshake.
module blk_coding_scheduler #(
   parameter int TBS = 16,
   parameter int G   = 132,
   parameter int TMO = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_data,
   input  logic        i_crc_valid,
   input  logic        i_turbo_valid,
   input  logic        i_rm_valid,
   output logic        o_data_req,
   output logic        o_data_crc,
   output logic        o_enable_turbo,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [15:0] o_bit_cnt
);

   localparam int LW = (TBS > 1) ? $clog2(TBS) : 1;
   localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [LW-1:0] LOAD_LAST = LW'(TBS - 1);
   localparam logic [WW-1:0] WD_LAST   = WW'(TMO - 1);
   localparam logic [15:0]   CNT_LAST  = 16'(G - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_CRC, ENCODE, RATE_MATCH, DONE, ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] load_cnt_q, load_cnt_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [15:0]   bit_cnt_q, bit_cnt_d;
   logic          data_req_q, data_req_d;
   logic          data_crc_q, data_crc_d;
   logic          enable_turbo_q, enable_turbo_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          wd_run;
   logic          qual_evt;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      wd_d       = wd_q;
      bit_cnt_d  = bit_cnt_q;
      wd_run     = 1'b0;
      qual_evt   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d    = LOAD;
               bit_cnt_d  = '0;
               load_cnt_d = '0;
            end
         end
         LOAD: begin
            if (load_cnt_q == LOAD_LAST) state_d = WAIT_CRC;
            else                         load_cnt_d = load_cnt_q + 1'b1;
         end
         WAIT_CRC: begin
            wd_run = 1'b1;
            if (i_crc_valid) begin
               qual_evt = 1'b1;
               state_d  = ENCODE;
            end
         end
         ENCODE: begin
            wd_run = 1'b1;
            if (i_turbo_valid) begin
               qual_evt = 1'b1;
               state_d  = RATE_MATCH;
            end
         end
         RATE_MATCH: begin
            wd_run = 1'b1;
            if (i_rm_valid) begin
               qual_evt  = 1'b1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_LAST) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Expiry is only tested when no event fired, so a same-cycle event wins.
      if (state_d != state_q || qual_evt) begin
         wd_d = '0;
      end else if (wd_run) begin
         if (wd_q == WD_LAST) begin
            state_d = ERROR;
            wd_d    = '0;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end

      data_req_d     = (state_d == LOAD);
      data_crc_d     = data_req_q & i_data;
      enable_turbo_d = (state_d == ENCODE) || (state_d == RATE_MATCH);
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == DONE);
      error_d        = (state_d == ERROR);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q        <= IDLE;
         load_cnt_q     <= '0;
         wd_q           <= '0;
         bit_cnt_q      <= '0;
         data_req_q     <= 1'b0;
         data_crc_q     <= 1'b0;
         enable_turbo_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_cnt_q     <= load_cnt_d;
         wd_q           <= wd_d;
         bit_cnt_q      <= bit_cnt_d;
         data_req_q     <= data_req_d;
         data_crc_q     <= data_crc_d;
         enable_turbo_q <= enable_turbo_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   assign o_data_req     = data_req_q;
   assign o_data_crc     = data_crc_q;
   assign o_enable_turbo = enable_turbo_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_error        = error_q;
   assign o_bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_blk_coding_scheduler.sv
// Scoreboard bench for blk_coding_scheduler: directed scenarios push expected
// done/error pulses; a negedge monitor pops and compares them.
module tb_blk_coding_scheduler;

   localparam int TBS = 16;
   localparam int G   = 132;
   localparam int TMO = 1024;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic        i_data = 1'b0;
   logic        i_crc_valid = 1'b0;
   logic        i_turbo_valid = 1'b0;
   logic        i_rm_valid = 1'b0;
   logic        o_data_req, o_data_crc, o_enable_turbo, o_busy, o_done, o_error;
   logic [15:0] o_bit_cnt;

   blk_coding_scheduler #(.TBS(TBS), .G(G), .TMO(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
      .i_crc_valid(i_crc_valid), .i_turbo_valid(i_turbo_valid), .i_rm_valid(i_rm_valid),
      .o_data_req(o_data_req), .o_data_crc(o_data_crc), .o_enable_turbo(o_enable_turbo),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_bit_cnt(o_bit_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit is_err;
      int cyc;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always @(posedge i_clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) step();
   endtask

   // Payload source: free-running LFSR so the forwarded bits are non-trivial.
   initial begin : payload
      logic [15:0] pat;
      pat = 16'hACE1;
      forever begin
         step();
         pat    = {pat[14:0], pat[15] ^ pat[13] ^ pat[12] ^ pat[10]};
         i_data = pat[0];
      end
   end

   // Monitor: payload forwarding, counter stepping and completion pulses.
   logic prev_req = 1'b0, prev_dat = 1'b0;
   int   prev_cnt = 0;
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_req = 1'b0;
         prev_cnt = 0;
      end else begin
         chk("data_crc", int'(o_data_crc), prev_req ? int'(prev_dat) : 0);
         prev_req = o_data_req;
         prev_dat = i_data;
         if (int'(o_bit_cnt) != prev_cnt && o_bit_cnt != 16'd0)
            chk("bit_cnt_step", int'(o_bit_cnt), prev_cnt + 1);
         prev_cnt = int'(o_bit_cnt);
         if (o_done || o_error) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_pulse: done=%0d error=%0d, expected none (cycle %0d)",
                        o_done, o_error, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_error", int'(o_error), int'(e.is_err));
               chk("pulse_done", int'(o_done), int'(!e.is_err));
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_bit_cnt", int'(o_bit_cnt), e.cnt);
            end
         end
      end
   end

   // Full block: start now, crc/turbo at given offsets from the start edge.
   task automatic run_block(input int crc_at, input int turbo_at, input bit gapped);
      int n;
      n = cyc + 1;
      exp_q.push_back('{is_err: 1'b0,
                        cyc: n + turbo_at + (gapped ? 2 * G - 1 : G),
                        cnt: G});
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_cyc(n + crc_at - 1);
      i_crc_valid = 1'b1; step(); i_crc_valid = 1'b0;
      wait_cyc(n + turbo_at - 1);
      i_turbo_valid = 1'b1; step(); i_turbo_valid = 1'b0;
      for (int k = 0; k < G; k++) begin
         i_rm_valid = 1'b1; step();
         if (gapped) begin
            i_rm_valid = 1'b0; step();
         end
      end
      i_rm_valid = 1'b0;
   endtask

   initial begin : stim
      int n;
      int d;
      int t;
      repeat (3) step();
      chk("reset_outputs", int'({o_data_req, o_data_crc, o_enable_turbo, o_busy, o_done, o_error}), 0);
      chk("reset_bit_cnt", int'(o_bit_cnt), 0);
      i_rst = 1'b0;
      step();

      // Nominal with timing spot checks.
      n = cyc + 1;
      fork
         run_block(20, 30, 1'b0);
         begin
            wait_cyc(n);      chk("data_req_first", int'(o_data_req), 1);
            wait_cyc(n + 15); chk("data_req_last", int'(o_data_req), 1);
            wait_cyc(n + 16); chk("data_req_off", int'(o_data_req), 0);
            wait_cyc(n + 19); chk("turbo_before", int'(o_enable_turbo), 0);
            wait_cyc(n + 20); chk("turbo_on", int'(o_enable_turbo), 1);
         end
      join
      step(); step();
      chk("nominal_bit_cnt_hold", int'(o_bit_cnt), G);
      chk("nominal_idle", int'(o_busy), 0);

      // Gapped rate-matcher pulses.
      run_block(25, 40, 1'b1);
      repeat (3) step();

      // Timeout waiting for CRC.
      n = cyc + 1;
      exp_q.push_back('{is_err: 1'b1, cyc: n + 16 + TMO, cnt: 0});
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_cyc(n + 16 + TMO - 1);
      chk("timeout_busy_before", int'(o_busy), 1);
      wait_cyc(n + 16 + TMO + 1);
      chk("timeout_busy_after", int'(o_busy), 0);
      chk("timeout_no_done", int'(o_done), 0);
      step();

      // CRC exactly at watchdog count TMO-1.
      n = cyc + 1;
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_cyc(n + 16 + TMO - 1);
      i_crc_valid = 1'b1; step(); i_crc_valid = 1'b0;
      chk("boundary_encode", int'(o_enable_turbo), 1);
      chk("boundary_no_error", int'(o_error), 0);
      i_turbo_valid = 1'b1; step(); i_turbo_valid = 1'b0;
      t = cyc;
      exp_q.push_back('{is_err: 1'b0, cyc: t + G, cnt: G});
      for (int k = 0; k < G; k++) begin
         i_rm_valid = 1'b1; step();
      end
      i_rm_valid = 1'b0;
      repeat (3) step();

      // Ignored inputs: start/crc in LOAD, turbo/rm in WAIT_CRC, start in DONE.
      n = cyc + 1;
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_cyc(n + 4);  i_start = 1'b1;     step(); i_start = 1'b0;
      wait_cyc(n + 7);  i_crc_valid = 1'b1; step(); i_crc_valid = 1'b0;
      wait_cyc(n + 16); chk("ign_load_len", int'(o_data_req), 0);
      wait_cyc(n + 19);
      i_turbo_valid = 1'b1; i_rm_valid = 1'b1; step();
      i_turbo_valid = 1'b0; i_rm_valid = 1'b0;
      wait_cyc(n + 40);
      chk("ign_wait_busy", int'(o_busy), 1);
      chk("ign_wait_turbo", int'(o_enable_turbo), 0);
      chk("ign_wait_cnt", int'(o_bit_cnt), 0);
      wait_cyc(n + 44); i_crc_valid = 1'b1;   step(); i_crc_valid = 1'b0;
      wait_cyc(n + 49); i_turbo_valid = 1'b1; step(); i_turbo_valid = 1'b0;
      exp_q.push_back('{is_err: 1'b0, cyc: n + 50 + G, cnt: G});
      for (int k = 0; k < G; k++) begin
         i_rm_valid = 1'b1; step();
      end
      i_rm_valid = 1'b0;
      d = cyc;
      i_start = 1'b1; step(); i_start = 1'b0;
      chk("ign_done_start_d1", int'(o_busy), 0);
      wait_cyc(d + 3);
      chk("ign_done_start_d3", int'(o_busy), 0);

      // Reset mid rate-match at bit count 50.
      n = cyc + 1;
      i_start = 1'b1; step(); i_start = 1'b0;
      wait_cyc(n + 19); i_crc_valid = 1'b1;   step(); i_crc_valid = 1'b0;
      wait_cyc(n + 29); i_turbo_valid = 1'b1; step(); i_turbo_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         i_rm_valid = 1'b1; step();
      end
      chk("pre_reset_cnt", int'(o_bit_cnt), 50);
      i_rst = 1'b1;
      #1;
      chk("async_reset_outputs", int'({o_data_req, o_data_crc, o_enable_turbo, o_busy, o_done, o_error}), 0);
      chk("async_reset_cnt", int'(o_bit_cnt), 0);
      i_rm_valid = 1'b0;
      step(); step();
      i_rst = 1'b0;
      run_block(20, 30, 1'b0);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL missing_pulse: no pulse seen, expected %s at cycle %0d",
                  e.is_err ? "error" : "done", e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/blk_coding_scheduler.md
BLK_CODING_SCHEDULER -- requirements
Module: blk_coding_scheduler

Interface
REQ-001 The block SHALL have parameter TBS, default 16, giving the transport block size in bits fed to CRC attachment.
REQ-002 The block SHALL have parameter G, default 132, giving the number of rate-matched output bits per block (1..65535).
REQ-003 The block SHALL have parameter TMO, default 1024, giving the watchdog limit in cycles.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-005 The block SHALL have port i_clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port i_start, input, 1 bit: request to code one block.
REQ-008 The block SHALL have port i_data, input, 1 bit: serial payload bit from the source.
REQ-009 The block SHALL have port i_crc_valid, input, 1 bit: CRC-attached block ready.
REQ-010 The block SHALL have port i_turbo_valid, input, 1 bit: turbo streams ready.
REQ-011 The block SHALL have port i_rm_valid, input, 1 bit: rate matcher emitted one bit this cycle.
REQ-012 The block SHALL have port o_data_req, output, 1 bit: payload bit requested.
REQ-013 The block SHALL have port o_data_crc, output, 1 bit: payload bit forwarded to CRC.
REQ-014 The block SHALL have port o_enable_turbo, output, 1 bit: turbo encoder enable.
REQ-015 The block SHALL have port o_busy, output, 1 bit: block in progress.
REQ-016 The block SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-017 The block SHALL have port o_error, output, 1 bit: one-cycle watchdog abort pulse.
REQ-018 The block SHALL have port o_bit_cnt, output, 16 bits: rate-matched bits counted.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, WAIT_CRC, ENCODE, RATE_MATCH, DONE and ERROR, and all outputs SHALL be registered.
REQ-020 In IDLE, i_start=1 at edge N SHALL enter LOAD and clear o_bit_cnt to 0; i_start SHALL be ignored in every other state.
REQ-021 In LOAD, o_data_req SHALL be 1 for exactly TBS cycles, N+1..N+TBS, then the FSM SHALL enter WAIT_CRC.
REQ-022 o_data_crc SHALL equal the i_data value sampled while o_data_req=1, presented one cycle later, and SHALL be 0 otherwise.
REQ-023 i_crc_valid SHALL be qualified only in WAIT_CRC; when it is 1, the FSM SHALL enter ENCODE.
REQ-024 o_enable_turbo SHALL be 1 throughout ENCODE and RATE_MATCH and 0 elsewhere.
REQ-025 i_turbo_valid SHALL be qualified only in ENCODE; when it is 1, the FSM SHALL enter RATE_MATCH.
REQ-026 In RATE_MATCH, each cycle with i_rm_valid=1 SHALL increment o_bit_cnt; the increment taking it to G SHALL enter DONE.
REQ-027 o_bit_cnt SHALL hold its value outside RATE_MATCH until the next accepted i_start and SHALL never exceed G.
REQ-028 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-029 A watchdog counter SHALL clear on every state entry and on every qualified event, and SHALL run in WAIT_CRC, ENCODE and RATE_MATCH.
REQ-030 When the watchdog reaches TMO-1 with no qualified event, the FSM SHALL enter ERROR.
REQ-031 ERROR SHALL assert o_error for exactly one cycle, return to IDLE, and leave o_done at 0.
REQ-032 If a qualified event and watchdog expiry occur in the same cycle, the event SHALL win.
REQ-033 o_busy SHALL be 1 in every state except IDLE.
REQ-034 Valid inputs arriving outside their qualifying state SHALL be ignored and not stored.

Reset
REQ-035 While i_rst=1, the FSM SHALL be IDLE, all counters SHALL be 0, and all outputs SHALL be 0, taking effect immediately and independent of the clock.
REQ-036 Reset mid-operation SHALL abandon the block with no o_done or o_error pulse; the first edge after release SHALL accept i_start.

Verification
REQ-037 Nominal (TBS=16, G=132): i_start at cycle 0, i_crc_valid at 20, i_turbo_valid at 30, then i_rm_valid continuous -> o_data_req high 1..16, o_enable_turbo high from 21, single o_done pulse the cycle after the 132nd valid, o_bit_cnt=132.
REQ-038 Gapped: 132 i_rm_valid pulses with one-cycle gaps -> o_done only after the 132nd pulse, o_bit_cnt stepping by 1.
REQ-039 Timeout: no i_crc_valid for TMO cycles -> one o_error pulse, o_busy low the next cycle, no o_done.
REQ-040 Boundary: i_crc_valid exactly at watchdog count TMO-1 -> ENCODE entered, no o_error.
REQ-041 Ignored inputs: i_start in LOAD and DONE, and i_crc_valid in LOAD -> no restart, and the FSM still waits in WAIT_CRC.
REQ-042 Reset at o_bit_cnt=50 -> all outputs 0 immediately; a new i_start then completes normally from o_bit_cnt=0.
